// File: rtl/cgra_top.sv
// rtl/cgra_top.sv - Reduced CGRA top: four 16-bit sides, one configurable registered operator per side
// Ports:
//   clk_in, reset_in (async active-low)       clock and reset
//   config_addr_in/config_data_in             32-bit config bus; address 1..4 selects CFG[0..3]
//   pad_S<s>_T<t>_in / _out                   per-side 16-bit words, T0 is the MSB
//   tdi, tms, tck, trst_n / tdo               JTAG pins kept for pin compatibility; tdo is 0
module cgra_top (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] config_addr_in,
  input  logic [31:0] config_data_in,
  input  logic pad_S0_T0_in,  pad_S0_T1_in,  pad_S0_T2_in,  pad_S0_T3_in,  pad_S0_T4_in,  pad_S0_T5_in,  pad_S0_T6_in,  pad_S0_T7_in,
  input  logic pad_S0_T8_in,  pad_S0_T9_in,  pad_S0_T10_in, pad_S0_T11_in, pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in,
  input  logic pad_S1_T0_in,  pad_S1_T1_in,  pad_S1_T2_in,  pad_S1_T3_in,  pad_S1_T4_in,  pad_S1_T5_in,  pad_S1_T6_in,  pad_S1_T7_in,
  input  logic pad_S1_T8_in,  pad_S1_T9_in,  pad_S1_T10_in, pad_S1_T11_in, pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in,
  input  logic pad_S2_T0_in,  pad_S2_T1_in,  pad_S2_T2_in,  pad_S2_T3_in,  pad_S2_T4_in,  pad_S2_T5_in,  pad_S2_T6_in,  pad_S2_T7_in,
  input  logic pad_S2_T8_in,  pad_S2_T9_in,  pad_S2_T10_in, pad_S2_T11_in, pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in,
  input  logic pad_S3_T0_in,  pad_S3_T1_in,  pad_S3_T2_in,  pad_S3_T3_in,  pad_S3_T4_in,  pad_S3_T5_in,  pad_S3_T6_in,  pad_S3_T7_in,
  input  logic pad_S3_T8_in,  pad_S3_T9_in,  pad_S3_T10_in, pad_S3_T11_in, pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in,
  output logic pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out, pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
  output logic pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out, pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out,
  output logic pad_S1_T0_out, pad_S1_T1_out, pad_S1_T2_out, pad_S1_T3_out, pad_S1_T4_out, pad_S1_T5_out, pad_S1_T6_out, pad_S1_T7_out,
  output logic pad_S1_T8_out, pad_S1_T9_out, pad_S1_T10_out, pad_S1_T11_out, pad_S1_T12_out, pad_S1_T13_out, pad_S1_T14_out, pad_S1_T15_out,
  output logic pad_S2_T0_out, pad_S2_T1_out, pad_S2_T2_out, pad_S2_T3_out, pad_S2_T4_out, pad_S2_T5_out, pad_S2_T6_out, pad_S2_T7_out,
  output logic pad_S2_T8_out, pad_S2_T9_out, pad_S2_T10_out, pad_S2_T11_out, pad_S2_T12_out, pad_S2_T13_out, pad_S2_T14_out, pad_S2_T15_out,
  output logic pad_S3_T0_out, pad_S3_T1_out, pad_S3_T2_out, pad_S3_T3_out, pad_S3_T4_out, pad_S3_T5_out, pad_S3_T6_out, pad_S3_T7_out,
  output logic pad_S3_T8_out, pad_S3_T9_out, pad_S3_T10_out, pad_S3_T11_out, pad_S3_T12_out, pad_S3_T13_out, pad_S3_T14_out, pad_S3_T15_out,
  input  logic        tdi,
  input  logic        tms,
  input  logic        tck,
  input  logic        trst_n,
  output logic        tdo
);

  localparam int TRACKS = 16;
  localparam int SIDES  = 4;

  logic [TRACKS-1:0] in_w  [SIDES];
  logic [31:0]       cfg_q [SIDES];
  logic [31:0]       cfg_d [SIDES];
  logic [TRACKS-1:0] out_q [SIDES];
  logic [TRACKS-1:0] out_d [SIDES];

  // Pad T0 lands in the word MSB.
  assign in_w[0] = {pad_S0_T0_in, pad_S0_T1_in, pad_S0_T2_in, pad_S0_T3_in, pad_S0_T4_in, pad_S0_T5_in, pad_S0_T6_in, pad_S0_T7_in,
                    pad_S0_T8_in, pad_S0_T9_in, pad_S0_T10_in, pad_S0_T11_in, pad_S0_T12_in, pad_S0_T13_in, pad_S0_T14_in, pad_S0_T15_in};
  assign in_w[1] = {pad_S1_T0_in, pad_S1_T1_in, pad_S1_T2_in, pad_S1_T3_in, pad_S1_T4_in, pad_S1_T5_in, pad_S1_T6_in, pad_S1_T7_in,
                    pad_S1_T8_in, pad_S1_T9_in, pad_S1_T10_in, pad_S1_T11_in, pad_S1_T12_in, pad_S1_T13_in, pad_S1_T14_in, pad_S1_T15_in};
  assign in_w[2] = {pad_S2_T0_in, pad_S2_T1_in, pad_S2_T2_in, pad_S2_T3_in, pad_S2_T4_in, pad_S2_T5_in, pad_S2_T6_in, pad_S2_T7_in,
                    pad_S2_T8_in, pad_S2_T9_in, pad_S2_T10_in, pad_S2_T11_in, pad_S2_T12_in, pad_S2_T13_in, pad_S2_T14_in, pad_S2_T15_in};
  assign in_w[3] = {pad_S3_T0_in, pad_S3_T1_in, pad_S3_T2_in, pad_S3_T3_in, pad_S3_T4_in, pad_S3_T5_in, pad_S3_T6_in, pad_S3_T7_in,
                    pad_S3_T8_in, pad_S3_T9_in, pad_S3_T10_in, pad_S3_T11_in, pad_S3_T12_in, pad_S3_T13_in, pad_S3_T14_in, pad_S3_T15_in};

  assign {pad_S0_T0_out, pad_S0_T1_out, pad_S0_T2_out, pad_S0_T3_out, pad_S0_T4_out, pad_S0_T5_out, pad_S0_T6_out, pad_S0_T7_out,
          pad_S0_T8_out, pad_S0_T9_out, pad_S0_T10_out, pad_S0_T11_out, pad_S0_T12_out, pad_S0_T13_out, pad_S0_T14_out, pad_S0_T15_out} = out_q[0];
  assign {pad_S1_T0_out, pad_S1_T1_out, pad_S1_T2_out, pad_S1_T3_out, pad_S1_T4_out, pad_S1_T5_out, pad_S1_T6_out, pad_S1_T7_out,
          pad_S1_T8_out, pad_S1_T9_out, pad_S1_T10_out, pad_S1_T11_out, pad_S1_T12_out, pad_S1_T13_out, pad_S1_T14_out, pad_S1_T15_out} = out_q[1];
  assign {pad_S2_T0_out, pad_S2_T1_out, pad_S2_T2_out, pad_S2_T3_out, pad_S2_T4_out, pad_S2_T5_out, pad_S2_T6_out, pad_S2_T7_out,
          pad_S2_T8_out, pad_S2_T9_out, pad_S2_T10_out, pad_S2_T11_out, pad_S2_T12_out, pad_S2_T13_out, pad_S2_T14_out, pad_S2_T15_out} = out_q[2];
  assign {pad_S3_T0_out, pad_S3_T1_out, pad_S3_T2_out, pad_S3_T3_out, pad_S3_T4_out, pad_S3_T5_out, pad_S3_T6_out, pad_S3_T7_out,
          pad_S3_T8_out, pad_S3_T9_out, pad_S3_T10_out, pad_S3_T11_out, pad_S3_T12_out, pad_S3_T13_out, pad_S3_T14_out, pad_S3_T15_out} = out_q[3];

  // JTAG pins are folded into a constant-zero term so they count as used without affecting tdo.
  assign tdo = 1'b0 & (tdi ^ tms ^ tck ^ trst_n);

  function automatic logic [TRACKS-1:0] apply_op(input logic [31:0] cfg,
                                                 input logic [TRACKS-1:0] a,
                                                 input logic [TRACKS-1:0] b);
    logic [TRACKS-1:0] r;
    r = '0;
    unique case (cfg[2:0])
      3'd0: r = '0;
      3'd1: r = a;
      3'd2: r = a + b;
      3'd3: r = a - b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      3'd7: r = cfg[31:16];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Outputs are computed from the current (pre-write) CFG, so a same-edge write
  // only influences the following edge.
  always_comb begin
    for (int k = 0; k < SIDES; k++) begin
      cfg_d[k] = cfg_q[k];
      out_d[k] = apply_op(cfg_q[k], in_w[cfg_q[k][5:4]], in_w[cfg_q[k][7:6]]);
      if (config_addr_in == 32'(k + 1)) begin
        cfg_d[k] = config_data_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int k = 0; k < SIDES; k++) begin
        cfg_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SIDES; k++) begin
        cfg_q[k] <= cfg_d[k];
        out_q[k] <= out_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cgra_top.sv
// tb/tb_cgra_top.sv - Randomized self-checking bench for cgra_top against a word-level reference model
module tb_cgra_top;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] config_addr_in;
  logic [31:0] config_data_in;
  logic        tdi, tms, tck, trst_n;
  wire         tdo;
  logic [15:0] in_w [4];
  wire  [15:0] out_w [4];

  int checks = 0;
  int failures = 0;

  logic [31:0] cfg_m [4];
  logic [15:0] out_m [4];
  logic [15:0] saved [4];

  always #5 clk_in = ~clk_in;

  cgra_top dut (
    .clk_in(clk_in), .reset_in(reset_in), .config_addr_in(config_addr_in), .config_data_in(config_data_in),
    .pad_S0_T0_in(in_w[0][15]), .pad_S0_T1_in(in_w[0][14]), .pad_S0_T2_in(in_w[0][13]), .pad_S0_T3_in(in_w[0][12]),
    .pad_S0_T4_in(in_w[0][11]), .pad_S0_T5_in(in_w[0][10]), .pad_S0_T6_in(in_w[0][9]),  .pad_S0_T7_in(in_w[0][8]),
    .pad_S0_T8_in(in_w[0][7]),  .pad_S0_T9_in(in_w[0][6]),  .pad_S0_T10_in(in_w[0][5]), .pad_S0_T11_in(in_w[0][4]),
    .pad_S0_T12_in(in_w[0][3]), .pad_S0_T13_in(in_w[0][2]), .pad_S0_T14_in(in_w[0][1]), .pad_S0_T15_in(in_w[0][0]),
    .pad_S1_T0_in(in_w[1][15]), .pad_S1_T1_in(in_w[1][14]), .pad_S1_T2_in(in_w[1][13]), .pad_S1_T3_in(in_w[1][12]),
    .pad_S1_T4_in(in_w[1][11]), .pad_S1_T5_in(in_w[1][10]), .pad_S1_T6_in(in_w[1][9]),  .pad_S1_T7_in(in_w[1][8]),
    .pad_S1_T8_in(in_w[1][7]),  .pad_S1_T9_in(in_w[1][6]),  .pad_S1_T10_in(in_w[1][5]), .pad_S1_T11_in(in_w[1][4]),
    .pad_S1_T12_in(in_w[1][3]), .pad_S1_T13_in(in_w[1][2]), .pad_S1_T14_in(in_w[1][1]), .pad_S1_T15_in(in_w[1][0]),
    .pad_S2_T0_in(in_w[2][15]), .pad_S2_T1_in(in_w[2][14]), .pad_S2_T2_in(in_w[2][13]), .pad_S2_T3_in(in_w[2][12]),
    .pad_S2_T4_in(in_w[2][11]), .pad_S2_T5_in(in_w[2][10]), .pad_S2_T6_in(in_w[2][9]),  .pad_S2_T7_in(in_w[2][8]),
    .pad_S2_T8_in(in_w[2][7]),  .pad_S2_T9_in(in_w[2][6]),  .pad_S2_T10_in(in_w[2][5]), .pad_S2_T11_in(in_w[2][4]),
    .pad_S2_T12_in(in_w[2][3]), .pad_S2_T13_in(in_w[2][2]), .pad_S2_T14_in(in_w[2][1]), .pad_S2_T15_in(in_w[2][0]),
    .pad_S3_T0_in(in_w[3][15]), .pad_S3_T1_in(in_w[3][14]), .pad_S3_T2_in(in_w[3][13]), .pad_S3_T3_in(in_w[3][12]),
    .pad_S3_T4_in(in_w[3][11]), .pad_S3_T5_in(in_w[3][10]), .pad_S3_T6_in(in_w[3][9]),  .pad_S3_T7_in(in_w[3][8]),
    .pad_S3_T8_in(in_w[3][7]),  .pad_S3_T9_in(in_w[3][6]),  .pad_S3_T10_in(in_w[3][5]), .pad_S3_T11_in(in_w[3][4]),
    .pad_S3_T12_in(in_w[3][3]), .pad_S3_T13_in(in_w[3][2]), .pad_S3_T14_in(in_w[3][1]), .pad_S3_T15_in(in_w[3][0]),
    .pad_S0_T0_out(out_w[0][15]), .pad_S0_T1_out(out_w[0][14]), .pad_S0_T2_out(out_w[0][13]), .pad_S0_T3_out(out_w[0][12]),
    .pad_S0_T4_out(out_w[0][11]), .pad_S0_T5_out(out_w[0][10]), .pad_S0_T6_out(out_w[0][9]),  .pad_S0_T7_out(out_w[0][8]),
    .pad_S0_T8_out(out_w[0][7]),  .pad_S0_T9_out(out_w[0][6]),  .pad_S0_T10_out(out_w[0][5]), .pad_S0_T11_out(out_w[0][4]),
    .pad_S0_T12_out(out_w[0][3]), .pad_S0_T13_out(out_w[0][2]), .pad_S0_T14_out(out_w[0][1]), .pad_S0_T15_out(out_w[0][0]),
    .pad_S1_T0_out(out_w[1][15]), .pad_S1_T1_out(out_w[1][14]), .pad_S1_T2_out(out_w[1][13]), .pad_S1_T3_out(out_w[1][12]),
    .pad_S1_T4_out(out_w[1][11]), .pad_S1_T5_out(out_w[1][10]), .pad_S1_T6_out(out_w[1][9]),  .pad_S1_T7_out(out_w[1][8]),
    .pad_S1_T8_out(out_w[1][7]),  .pad_S1_T9_out(out_w[1][6]),  .pad_S1_T10_out(out_w[1][5]), .pad_S1_T11_out(out_w[1][4]),
    .pad_S1_T12_out(out_w[1][3]), .pad_S1_T13_out(out_w[1][2]), .pad_S1_T14_out(out_w[1][1]), .pad_S1_T15_out(out_w[1][0]),
    .pad_S2_T0_out(out_w[2][15]), .pad_S2_T1_out(out_w[2][14]), .pad_S2_T2_out(out_w[2][13]), .pad_S2_T3_out(out_w[2][12]),
    .pad_S2_T4_out(out_w[2][11]), .pad_S2_T5_out(out_w[2][10]), .pad_S2_T6_out(out_w[2][9]),  .pad_S2_T7_out(out_w[2][8]),
    .pad_S2_T8_out(out_w[2][7]),  .pad_S2_T9_out(out_w[2][6]),  .pad_S2_T10_out(out_w[2][5]), .pad_S2_T11_out(out_w[2][4]),
    .pad_S2_T12_out(out_w[2][3]), .pad_S2_T13_out(out_w[2][2]), .pad_S2_T14_out(out_w[2][1]), .pad_S2_T15_out(out_w[2][0]),
    .pad_S3_T0_out(out_w[3][15]), .pad_S3_T1_out(out_w[3][14]), .pad_S3_T2_out(out_w[3][13]), .pad_S3_T3_out(out_w[3][12]),
    .pad_S3_T4_out(out_w[3][11]), .pad_S3_T5_out(out_w[3][10]), .pad_S3_T6_out(out_w[3][9]),  .pad_S3_T7_out(out_w[3][8]),
    .pad_S3_T8_out(out_w[3][7]),  .pad_S3_T9_out(out_w[3][6]),  .pad_S3_T10_out(out_w[3][5]), .pad_S3_T11_out(out_w[3][4]),
    .pad_S3_T12_out(out_w[3][3]), .pad_S3_T13_out(out_w[3][2]), .pad_S3_T14_out(out_w[3][1]), .pad_S3_T15_out(out_w[3][0]),
    .tdi(tdi), .tms(tms), .tck(tck), .trst_n(trst_n), .tdo(tdo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level meaning of each operator code.
  function automatic logic [15:0] model_op(input logic [31:0] cfg, input logic [15:0] a, input logic [15:0] b);
    int unsigned ia = a;
    int unsigned ib = b;
    case (cfg[2:0])
      3'd1:    return a;
      3'd2:    return 16'((ia + ib) % 65536);
      3'd3:    return 16'((ia + 65536 - ib) % 65536);
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      3'd7:    return cfg[31:16];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      cfg_m[k] = 32'h0;
      out_m[k] = 16'h0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) check($sformatf("%s_out%0d", tag, k), 32'(out_w[k]), 32'(out_m[k]));
    check($sformatf("%s_tdo", tag), 32'(tdo), 32'h0);
  endtask

  // One clock: present config bus, update model at the edge (old CFG for OUT), compare after.
  task automatic step(input logic [31:0] addr, input logic [31:0] data, input string tag);
    @(negedge clk_in);
    config_addr_in = addr;
    config_data_in = data;
    @(posedge clk_in);
    if (reset_in) begin
      for (int k = 0; k < 4; k++) out_m[k] = model_op(cfg_m[k], in_w[cfg_m[k][5:4]], in_w[cfg_m[k][7:6]]);
      if (addr >= 1 && addr <= 4) cfg_m[addr - 1] = data;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    reset_in = 1'b0;
    config_addr_in = 32'h0;
    config_data_in = 32'h0;
    {tdi, tms, tck, trst_n} = 4'b1010;
    for (int s = 0; s < 4; s++) in_w[s] = 16'h0003;
    model_clear();
    #3;
    check_all("reset_held");
    step(32'h0, 32'h0, "reset_clk");
    @(negedge clk_in);
    reset_in = 1'b1;
    step(32'h0, 32'h0, "post_reset");

    step(32'd1, 32'h00000021, "pass_wr");
    step(32'd0, 32'h0, "pass");
    check("pass_out0_const", 32'(out_w[0]), 32'h0003);
    check("pass_t14", 32'(dut.pad_S0_T14_out), 32'h1);
    check("pass_t0", 32'(dut.pad_S0_T0_out), 32'h0);

    in_w[1] = 16'hFFFF;
    in_w[3] = 16'h0002;
    step(32'd3, 32'h000000D2, "add_wr");
    step(32'd0, 32'h0, "add");
    check("add_wrap_const", 32'(out_w[2]), 32'h0001);

    step(32'd4, 32'hBEEF0007, "const_wr");
    step(32'd0, 32'h0, "const");
    check("const_out3", 32'(out_w[3]), 32'hBEEF);

    in_w[1] = 16'h0005;
    in_w[0] = 16'h0007;
    step(32'd2, 32'h00000013, "sub_wr");
    step(32'd0, 32'h0, "sub");
    check("sub_out1", 32'(out_w[1]), 32'hFFFE);

    for (int k = 0; k < 4; k++) saved[k] = out_w[k];
    step(32'd0, 32'hFFFFFFFF, "idle");
    step(32'd9, 32'h00000007, "bad_addr");
    for (int k = 0; k < 4; k++) check($sformatf("unchanged_out%0d", k), 32'(out_w[k]), 32'(saved[k]));

    @(negedge clk_in);
    #2;
    reset_in = 1'b0;
    model_clear();
    #1;
    check_all("async_reset");
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, "after_reset");

    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < 4; s++) in_w[s] = 16'($urandom);
      {tdi, tms, tck, trst_n} = 4'($urandom);
      if (i == 300) begin
        @(negedge clk_in);
        #1;
        reset_in = 1'b0;
        model_clear();
        #1;
        check_all("rand_reset");
        #1;
        reset_in = 1'b1;
      end
      step(32'($urandom_range(0, 6)), $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
